// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter over a small 8-bit register bank.
// Optional burst lock is enabled with `define REG_ARB_LOCK_EN.
module reg_bank_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*AW-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   i_req_lock,
`endif
    output logic [GW-1:0]        o_grant_id,
    output logic                 o_wr_strobe,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [7:0]           o_rd_data
);

    logic [GW-1:0] r_ptr;
    logic [7:0]    r_bank [DEPTH];

    logic [GW-1:0] w_gnt;
    logic [GW-1:0] w_idx;
    logic [GW-1:0] w_next;
    logic          w_hit;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_data;

`ifdef REG_ARB_LOCK_EN
    typedef enum logic {S_IDLE, S_LOCKED} state_t;
    state_t        r_state;
    logic [GW-1:0] r_owner;
    logic [GW-1:0] w_own_next;

    assign w_own_next = (r_owner == GW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
`endif

    // Pick the first valid requester at or after the pointer (owner only when locked)
    always_comb begin
        o_req_ready = '0;
        w_gnt       = '0;
        w_idx       = '0;
        w_hit       = 1'b0;
`ifdef REG_ARB_LOCK_EN
        if (r_state == S_LOCKED) begin
            if (i_req_valid[r_owner]) begin
                w_hit = 1'b1;
                w_gnt = r_owner;
            end
        end else
`endif
        begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = GW'((int'(r_ptr) + k) % NUM_REQ);
                if (!w_hit && i_req_valid[w_idx]) begin
                    w_hit = 1'b1;
                    w_gnt = w_idx;
                end
            end
        end
        if (w_hit) o_req_ready[w_gnt] = 1'b1;
    end

    assign w_next = (w_gnt == GW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
    assign w_addr = i_req_addr[w_gnt*AW +: AW];
    assign w_data = i_req_data[w_gnt*8 +: 8];

    // Controller: pointer rotation, lock tracking, commit status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            o_grant_id  <= '0;
            o_wr_strobe <= 1'b0;
`ifdef REG_ARB_LOCK_EN
            r_state     <= S_IDLE;
            r_owner     <= '0;
`endif
        end else begin
            o_wr_strobe <= w_hit;
            if (w_hit) o_grant_id <= w_gnt;
`ifdef REG_ARB_LOCK_EN
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_ptr <= w_next;
                        if (i_req_lock[w_gnt]) begin
                            r_state <= S_LOCKED;
                            r_owner <= w_gnt;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!i_req_valid[r_owner] || !i_req_lock[r_owner]) begin
                        r_state <= S_IDLE;
                        r_ptr   <= w_own_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`else
            if (w_hit) r_ptr <= w_next;
`endif
        end
    end

    // Register bank storage, one committed write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= 8'h00;
        end else if (w_hit) begin
            r_bank[w_addr] <= w_data;
        end
    end

    // Registered read port with write-first bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data <= 8'h00;
        end else if (w_hit && (w_addr == i_rd_addr)) begin
            o_rd_data <= w_data;
        end else begin
            o_rd_data <= r_bank[i_rd_addr];
        end
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter and controller for a small bank of 8-bit registers built from async-reset DFF storage. Up to NUM_REQ requesters compete for the single shared write port through a valid/ready handshake; one write commits per cycle. A registered read port exposes the bank contents to downstream logic.

## Interface
- NUM_REQ, 4: number of write requesters, 2..8
- DEPTH, 4: number of 8-bit registers in the bank, power of 2, 2..16
- AW, $clog2(DEPTH): register address width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*AW  per-requester target register, requester i at [i*AW +: AW]
- req_data  in  NUM_REQ*8  per-requester write data, requester i at [i*8 +: 8]
- req_ready  out  NUM_REQ  one-hot grant; write of requester i commits on an edge where req_valid[i] && req_ready[i]
- req_lock  in  NUM_REQ  hold grant for a burst (present only with REG_ARB_LOCK_EN)
- grant_id  out  $clog2(NUM_REQ)  index of requester whose write committed last cycle
- wr_strobe  out  1  pulses high one cycle after each committed write
- rd_addr  in  AW  read address
- rd_data  out  8  registered read data

## Operation
- Arbitration is combinational on the current cycle: req_ready = one-hot of the first asserted req_valid at or after rr_ptr, searching upward with wrap to 0; all zero if no req_valid.
- req_ready never asserts for a requester whose req_valid is low; at most one bit set.
- On a committed write: bank[req_addr[g]] <= req_data[g]; rr_ptr <= (g+1) mod NUM_REQ; grant_id <= g; wr_strobe <= 1.
- No commit: rr_ptr, grant_id, bank hold; wr_strobe <= 0.
- Requester holding valid while not granted keeps its addr/data stable; it is granted within NUM_REQ cycles (no starvation, lock disabled).
- Two requesters writing the same address in consecutive cycles: later commit wins.
- rd_data <= bank[rd_addr] each edge. Same-cycle write and read of same address: rd_data takes the new write data (write-first bypass).
- Controller state: IDLE (no grant held) and LOCKED (lock build only). Without the macro the block is always IDLE.
- Reset (any time, including mid-burst): bank all 8'h00, rd_data 8'h00, rr_ptr 0, grant_id 0, wr_strobe 0, state IDLE; in-flight request is dropped, requester must re-present.

## Timing
- Grant latency: req_ready combinational from req_valid in same cycle; zero-wait when uncontended.
- Write-to-read: write at edge t, read of that address with rd_addr presented in cycle t+1 returns new value at edge t+1 (or at edge t via bypass if rd_addr matches in the write cycle).
- Read latency: 1 cycle from rd_addr to rd_data.
- wr_strobe, grant_id: 1 cycle after commit edge.
- Throughput: one write per cycle, sustained.

## Configuration
- REG_ARB_LOCK_EN defined: req_lock port exists. Committed write from g with req_lock[g]=1 enters LOCKED, owner=g; while LOCKED only g can be granted and rr_ptr frozen. Exit to IDLE on a commit with req_lock[g]=0, or when req_valid[g] drops (then rr_ptr <= g+1). Reset forces IDLE.
- Not defined: no req_lock port, no LOCKED state; pure round-robin as above.

## Test plan
- Reset: assert rst_n=0 mid-write -> all outputs and bank 8'h00, rr_ptr 0 asynchronously; read every address returns 8'h00.
- Single requester: req_valid=4'b0100, addr 2, data 8'hA5 -> req_ready=4'b0100 same cycle; next cycle wr_strobe=1, grant_id=2; rd_addr=2 then rd_data=8'hA5.
- Full contention: req_valid=4'b1111 held 8 cycles, distinct data -> grant order 0,1,2,3,0,1,2,3; each requester exactly 2 grants.
- Wrap: rr_ptr=3, req_valid=4'b0011 -> grant 0, then 1.
- Same-cycle bypass: write 8'h3C to addr 1 while rd_addr=1 -> rd_data=8'h3C next edge.
- Lock (REG_ARB_LOCK_EN): requester 1 with req_lock=1 for 3 writes while 0,2,3 valid -> three consecutive grants to 1, then grant to 2.
